// File: rtl/vga_timing_if.sv
// Video timing output bundle: syncs, active flag, coordinates and strobes.
interface vga_timing_if #(
  parameter int CW = 11
);
  logic          o_pix_en;
  logic          o_hs;
  logic          o_vs;
  logic          o_active;
  logic [CW-1:0] o_x;
  logic [CW-1:0] o_y;
  logic          o_line_start;
  logic          o_frame_start;

  modport master (
    output o_pix_en, o_hs, o_vs, o_active, o_x, o_y, o_line_start, o_frame_start
  );
  modport slave (
    input  o_pix_en, o_hs, o_vs, o_active, o_x, o_y, o_line_start, o_frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator with integer pixel-clock divider.
// Optional alternate timing set selected per frame when VGA_TIMING_ALTMODE_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 1,
  parameter int CW       = 11
`ifdef VGA_TIMING_ALTMODE_EN
  ,
  parameter int ALT_H_ACTIVE = H_ACTIVE,
  parameter int ALT_H_FP     = H_FP,
  parameter int ALT_H_SYNC   = H_SYNC,
  parameter int ALT_H_BP     = H_BP,
  parameter int ALT_V_ACTIVE = V_ACTIVE,
  parameter int ALT_V_FP     = V_FP,
  parameter int ALT_V_SYNC   = V_SYNC,
  parameter int ALT_V_BP     = V_BP
`endif
) (
  input  logic i_clk,
  input  logic i_rst,
`ifdef VGA_TIMING_ALTMODE_EN
  input  logic i_mode,
`endif
  vga_timing_if.master vid
);

  localparam int W  = CW + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic          HS_ON    = 1'(HS_POL);
  localparam logic          VS_ON    = 1'(VS_POL);

  // Boundaries are CW+1 bits wide so a sync that ends exactly at 2^CW still compares correctly.
  localparam logic [CW:0] P_H_ACT  = W'(H_ACTIVE);
  localparam logic [CW:0] P_H_SS   = W'(H_ACTIVE + H_FP);
  localparam logic [CW:0] P_H_SE   = W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] P_H_LAST = W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW:0] P_V_ACT  = W'(V_ACTIVE);
  localparam logic [CW:0] P_V_SS   = W'(V_ACTIVE + V_FP);
  localparam logic [CW:0] P_V_SE   = W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW:0] P_V_LAST = W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [CW:0] h_act, h_ss, h_se, h_last;
  logic [CW:0] v_act, v_ss, v_se, v_last;

`ifdef VGA_TIMING_ALTMODE_EN
  localparam logic [CW:0] A_H_ACT  = W'(ALT_H_ACTIVE);
  localparam logic [CW:0] A_H_SS   = W'(ALT_H_ACTIVE + ALT_H_FP);
  localparam logic [CW:0] A_H_SE   = W'(ALT_H_ACTIVE + ALT_H_FP + ALT_H_SYNC);
  localparam logic [CW:0] A_H_LAST = W'(ALT_H_ACTIVE + ALT_H_FP + ALT_H_SYNC + ALT_H_BP - 1);
  localparam logic [CW:0] A_V_ACT  = W'(ALT_V_ACTIVE);
  localparam logic [CW:0] A_V_SS   = W'(ALT_V_ACTIVE + ALT_V_FP);
  localparam logic [CW:0] A_V_SE   = W'(ALT_V_ACTIVE + ALT_V_FP + ALT_V_SYNC);
  localparam logic [CW:0] A_V_LAST = W'(ALT_V_ACTIVE + ALT_V_FP + ALT_V_SYNC + ALT_V_BP - 1);

  logic alt_q;

  always_comb begin
    if (alt_q) begin
      h_act = A_H_ACT; h_ss = A_H_SS; h_se = A_H_SE; h_last = A_H_LAST;
      v_act = A_V_ACT; v_ss = A_V_SS; v_se = A_V_SE; v_last = A_V_LAST;
    end else begin
      h_act = P_H_ACT; h_ss = P_H_SS; h_se = P_H_SE; h_last = P_H_LAST;
      v_act = P_V_ACT; v_ss = P_V_SS; v_se = P_V_SE; v_last = P_V_LAST;
    end
  end
`else
  always_comb begin
    h_act = P_H_ACT; h_ss = P_H_SS; h_se = P_H_SE; h_last = P_H_LAST;
    v_act = P_V_ACT; v_ss = P_V_SS; v_se = P_V_SE; v_last = P_V_LAST;
  end
`endif

  logic [DW-1:0] div;
  logic [CW-1:0] h, v;
  logic [CW:0]   h_w, v_w;
  logic          pix_step, h_wrap, v_wrap;

  always_comb begin
    h_w      = {1'b0, h};
    v_w      = {1'b0, v};
    pix_step = (div == DIV_LAST);
    h_wrap   = pix_step && (h_w == h_last);
    v_wrap   = h_wrap && (v_w == v_last);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      div <= pix_step ? '0 : div + 1'b1;
      if (pix_step) h <= h_wrap ? '0 : h + 1'b1;
      if (h_wrap)   v <= v_wrap ? '0 : v + 1'b1;
    end
  end

`ifdef VGA_TIMING_ALTMODE_EN
  // Timing set only switches on the final clock of a frame, as the counters wrap to (0,0).
  always_ff @(posedge i_clk) begin
    if (i_rst)       alt_q <= 1'b0;
    else if (v_wrap) alt_q <= i_mode;
  end
`endif

  logic first_clk;
  always_comb first_clk = (div == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vid.o_pix_en      <= 1'b0;
      vid.o_hs          <= ~HS_ON;
      vid.o_vs          <= ~VS_ON;
      vid.o_active      <= 1'b0;
      vid.o_x           <= '0;
      vid.o_y           <= '0;
      vid.o_line_start  <= 1'b0;
      vid.o_frame_start <= 1'b0;
    end else begin
      vid.o_pix_en      <= first_clk;
      vid.o_hs          <= ((h_w >= h_ss) && (h_w < h_se)) ? HS_ON : ~HS_ON;
      vid.o_vs          <= ((v_w >= v_ss) && (v_w < v_se)) ? VS_ON : ~VS_ON;
      vid.o_active      <= (h_w < h_act) && (v_w < v_act);
      vid.o_x           <= h;
      vid.o_y           <= v;
      vid.o_line_start  <= first_clk && (h == '0);
      vid.o_frame_start <= first_clk && (h == '0) && (v == '0);
    end
  end

endmodule
